triangle_area: RTL and testbench

- Pipelined triangle-area unit. Takes three signed 2-D vertices and returns the absolute twice-area (shoelace determinant) and the half-area.
- Used as the building block of point-in-triangle tests. Typically four instances are used, one for the main triangle and three for the sub-triangles formed with the probe point.
- Uses a streaming valid-only interface with fixed latency and no backpressure.

---
 rtl/tri_geom_pkg.sv | 27 ++
 rtl/tri_cross_term.sv | 62 ++++++
 rtl/triangle_area.sv | 93 +++++++++
 tb/tb_triangle_area.sv | 131 +++++++++++++
 4 files changed

// File: rtl/tri_geom_pkg.sv
// Shared widths and types for the triangle-area datapath.
// Width helpers keep every stage exact for any coordinate width.
package tri_geom_pkg;

    localparam int DEF_COORD_W = 12;
    localparam int DEF_AREA_W  = 22;

    function automatic int diff_w(input int cw);
        return cw + 1;
    endfunction

    function automatic int prod_w(input int cw);
        return 2 * cw + 1;
    endfunction

    function automatic int sum_w(input int cw);
        return 2 * cw + 3;
    endfunction

    localparam int DIFF_W = diff_w(DEF_COORD_W);
    localparam int PROD_W = prod_w(DEF_COORD_W);
    localparam int SUM_W  = sum_w(DEF_COORD_W);

    typedef logic signed [DEF_COORD_W-1:0] coord_t;
    typedef logic [2*DEF_COORD_W+1:0]      area2_t;

endpackage

// File: rtl/tri_cross_term.sv
// One shoelace term x*(y_a-y_b): S1 registers the difference, S2 the product.
// Latency 2 cycles; valid-only, no backpressure (accepts every valid cycle).
module tri_cross_term
    import tri_geom_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic signed [COORD_W-1:0]          x,
    input  logic signed [COORD_W-1:0]          y_a,
    input  logic signed [COORD_W-1:0]          y_b,
    output logic                               out_valid,
    output logic signed [prod_w(COORD_W)-1:0]  prod
);

    localparam int DW = diff_w(COORD_W);
    localparam int PW = prod_w(COORD_W);

    logic                      s1_vld_d, s1_vld_q;
    logic                      s2_vld_d, s2_vld_q;
    logic signed [COORD_W-1:0] x_d, x_q;
    logic signed [DW-1:0]      diff_d, diff_q;
    logic signed [PW-1:0]      prod_d, prod_q;

    always_comb begin
        s1_vld_d = in_valid;
        s2_vld_d = s1_vld_q;
        x_d      = x_q;
        diff_d   = diff_q;
        prod_d   = prod_q;
        // x travels with the difference so both operands arrive at S2 together.
        if (in_valid) begin
            x_d    = x;
            diff_d = DW'(y_a) - DW'(y_b);
        end
        if (s1_vld_q) begin
            prod_d = PW'(x_q) * PW'(diff_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            x_q      <= '0;
            diff_q   <= '0;
            prod_q   <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            x_q      <= x_d;
            diff_q   <= diff_d;
            prod_q   <= prod_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign prod      = prod_q;

endmodule

// File: rtl/triangle_area.sv
// Absolute twice-area |D| and saturated half-area of a signed 2-D triangle.
// Latency 3 cycles, one sample per cycle; valid-only, no backpressure or stall.
module triangle_area
    import tri_geom_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int AREA_W  = DEF_AREA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    input  logic signed [COORD_W-1:0] x3,
    input  logic signed [COORD_W-1:0] y3,
    output logic                      out_valid,
    output logic [2*COORD_W+1:0]      area_x2,
    output logic [AREA_W-1:0]         area,
    output logic                      area_ovf
);

    localparam int PW  = prod_w(COORD_W);
    localparam int SW  = sum_w(COORD_W);
    localparam int A2W = 2 * COORD_W + 2;
    localparam int HW  = A2W - 1;

    logic                 vld_a, vld_b, vld_c;
    logic signed [PW-1:0] prod_a, prod_b, prod_c;

    tri_cross_term #(.COORD_W(COORD_W)) u_term_a (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x(x1), .y_a(y2), .y_b(y3), .out_valid(vld_a), .prod(prod_a)
    );

    tri_cross_term #(.COORD_W(COORD_W)) u_term_b (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x(x2), .y_a(y3), .y_b(y1), .out_valid(vld_b), .prod(prod_b)
    );

    tri_cross_term #(.COORD_W(COORD_W)) u_term_c (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x(x3), .y_a(y1), .y_b(y2), .out_valid(vld_c), .prod(prod_c)
    );

    logic                 s3_vld;
    logic signed [SW-1:0] sum;
    logic [SW-1:0]        mag;
    logic [HW-1:0]        half;

    logic                 out_valid_d, out_valid_q;
    logic [A2W-1:0]       area_x2_d, area_x2_q;
    logic [AREA_W-1:0]    area_d, area_q;
    logic                 area_ovf_d, area_ovf_q;

    always_comb begin
        s3_vld      = vld_a & vld_b & vld_c;
        sum         = SW'(prod_a) + SW'(prod_b) + SW'(prod_c);
        mag         = sum[SW-1] ? $unsigned(-sum) : $unsigned(sum);
        half        = HW'(mag >> 1);
        out_valid_d = s3_vld;
        area_x2_d   = area_x2_q;
        area_d      = area_q;
        area_ovf_d  = area_ovf_q;
        if (s3_vld) begin
            area_x2_d  = A2W'(mag);
            // Any set bit at or above AREA_W means the half-area does not fit.
            area_ovf_d = (half >> AREA_W) != '0;
            area_d     = area_ovf_d ? '1 : AREA_W'(half);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            area_x2_q   <= '0;
            area_q      <= '0;
            area_ovf_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            area_x2_q   <= area_x2_d;
            area_q      <= area_d;
            area_ovf_q  <= area_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign area_x2   = area_x2_q;
    assign area      = area_q;
    assign area_ovf  = area_ovf_q;

endmodule

// File: tb/tb_triangle_area.sv
// Directed bench for triangle_area: latency, winding, degenerate, saturation, streaming, reset flush.
module tb_triangle_area;

    localparam int CW = 12;
    localparam int AW = 22;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [CW-1:0] x1, y1, x2, y2, x3, y3;
    logic                 out_valid;
    logic [2*CW+1:0]      area_x2;
    logic [AW-1:0]        area;
    logic                 area_ovf;

    int checks = 0;
    int errors = 0;

    triangle_area #(.COORD_W(CW), .AREA_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .out_valid(out_valid), .area_x2(area_x2), .area(area), .area_ovf(area_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
        in_valid = 1'b1;
        x1 = CW'(ax); y1 = CW'(ay);
        x2 = CW'(bx); y2 = CW'(by);
        x3 = CW'(cx); y3 = CW'(cy);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        x1 = 'x; y1 = 'x; x2 = 'x; y2 = 'x; x3 = 'x; y3 = 'x;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] e_x2,
                           input logic [63:0] e_area, input logic e_ovf);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".area_x2"}, area_x2, e_x2);
        chk({tag, ".area"}, area, e_area);
        chk({tag, ".ovf"}, area_ovf, e_ovf);
    endtask

    // Single sample: out_valid must be low 2 cycles after issue, high exactly at 3, low again at 4.
    task automatic run_one(input string tag, input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy,
                           input logic [63:0] e_x2, input logic [63:0] e_area, input logic e_ovf);
        drive(ax, ay, bx, by, cx, cy);
        @(negedge clk); idle();
        @(negedge clk); chk({tag, ".early"}, out_valid, 0);
        @(negedge clk); chk_out(tag, e_x2, e_area, e_ovf);
        @(negedge clk);
        chk({tag, ".drop"}, out_valid, 0);
        chk({tag, ".hold"}, area_x2, e_x2);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst.valid", out_valid, 0);
        chk("rst.area_x2", area_x2, 0);
        chk("rst.area", area, 0);
        chk("rst.ovf", area_ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_x.valid", out_valid, 0);
        chk("idle_x.area_x2", area_x2, 0);

        run_one("v1", 10, 10, 5, 30, 15, 25, 175, 87, 1'b0);
        run_one("v2", 5, 10, 5, 30, 15, 25, 200, 100, 1'b0);
        run_one("v2rev", 15, 25, 5, 30, 5, 10, 200, 100, 1'b0);
        run_one("collinear", 0, 0, 1, 1, 2, 2, 0, 0, 1'b0);
        run_one("coincident", 7, -3, 7, -3, 7, -3, 0, 0, 1'b0);
        run_one("extreme", -2048, -2048, 2047, -2048, -2048, 2047, 16769025, 4194303, 1'b1);
        run_one("v1again", 10, 10, 5, 30, 15, 25, 175, 87, 1'b0);

        // Back-to-back stream, results must come out on consecutive cycles in order.
        drive(10, 10, 5, 30, 15, 25);
        @(negedge clk); drive(5, 10, 5, 30, 15, 25);
        @(negedge clk); drive(15, 25, 5, 30, 5, 10);
        @(negedge clk); idle();
        chk_out("stream0", 175, 87, 1'b0);
        @(negedge clk); chk_out("stream1", 200, 100, 1'b0);
        @(negedge clk); chk_out("stream2", 200, 100, 1'b0);
        @(negedge clk); chk("stream.end", out_valid, 0);

        // Two samples in flight when reset hits; neither may ever surface.
        drive(-2048, -2048, 2047, -2048, -2048, 2047);
        @(negedge clk); drive(5, 10, 5, 30, 15, 25);
        @(negedge clk); idle();
        rst = 1'b1;
        #1;
        chk("rstmid.valid", out_valid, 0);
        chk("rstmid.area_x2", area_x2, 0);
        chk("rstmid.area", area, 0);
        chk("rstmid.ovf", area_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flushed.valid", out_valid, 0);
        end
        chk("flushed.area_x2", area_x2, 0);

        run_one("postrst", 10, 10, 5, 30, 15, 25, 175, 87, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
